// File: rtl/trellis_bidir_io_bank.sv
// ---------------------------------------------------------------------------
// trellis_bidir_io_bank
//
// A bank of WIDTH bidirectional pad buffers that behave like the ECP5
// TRELLIS_IO primitive. It is intended as the buffer for the FT2232H FIFO
// data bus. All bits share one tristate control. Each bit has its own drive
// value and its own received value.
//
// The pad path is purely combinational. On top of it the bank registers the
// received value and a "bank is driving" flag on fifo_clk_i, so that
// consumers can take timing-closed versions of both.
//
// Parameters:
//   WIDTH  number of pad bits in the bank (default 8)
//   DIR    buffer mode: "BIDIR", "INPUT" or "OUTPUT". Any other value stops
//          elaboration.
//
// Ports:
//   fifo_clk_i  in     clock for the registered outputs
//   reset_i     in     asynchronous, active-high reset (registered path only)
//   B           inout  pad bus
//   T           in     tristate: 1 = pads high-Z (receive), 0 = drive I
//   I           in     per-bit value driven onto the pads when driving
//   O           out    combinational received value
//   O_q         out    O registered on the rising edge of fifo_clk_i
//   drive_q     out    registered "bank is driving the pads" flag
// ---------------------------------------------------------------------------
module trellis_bidir_io_bank #(
  parameter int    WIDTH = 8,
  parameter string DIR   = "BIDIR"
) (
  input  logic             fifo_clk_i,
  input  logic             reset_i,
  inout  wire  [WIDTH-1:0] B,
  input  logic             T,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] O_q,
  output logic             drive_q
);

  localparam bit IsBidir  = (DIR == "BIDIR");
  localparam bit IsInput  = (DIR == "INPUT");
  localparam bit IsOutput = (DIR == "OUTPUT");

  // An unknown mode is a configuration mistake, so stop elaboration here
  // instead of building a buffer with undefined behaviour.
  generate
    if (!(IsBidir || IsInput || IsOutput)) begin : g_bad_dir
      $error("trellis_bidir_io_bank: DIR must be BIDIR, INPUT or OUTPUT");
    end
  endgenerate

  // ------------------------------------------------------------------------
  // Combinational pad path
  // ------------------------------------------------------------------------
  logic             drive_en;
  logic [WIDTH-1:0] o_d;
  logic [WIDTH-1:0] drive_en_bits;

  // In BIDIR mode drive_en comes straight from T. An X on T therefore gives
  // an X enable, and the pad then resolves to X.
  always_comb begin
    drive_en = 1'b0;
    if (IsOutput) begin
      drive_en = 1'b1;
    end else if (IsBidir) begin
      drive_en = ~T;
    end
  end

  // There is no turnaround guard cycle. A change on T reaches the pads at
  // once. The controller that instantiates this bank must leave a high-Z
  // cycle between directions.
  assign drive_en_bits = {WIDTH{drive_en}};
  assign B = drive_en_bits[0] ? I : {WIDTH{1'bz}};

  // OUTPUT mode reports the drive value. The other modes report the
  // resolved pad, which equals I while this bank is driving. A floating
  // pad is passed through as is, because there is no pull-up or keeper.
  always_comb begin
    o_d = B;
    if (IsOutput) begin
      o_d = I;
    end
  end

  assign O = o_d;

  // ------------------------------------------------------------------------
  // Registered path: O_q lags O by exactly one clock. Reset clears only
  // these flops. The pads keep following T/DIR while reset_i is high.
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0] o_q_d;
  logic             drive_q_d;

  assign o_q_d     = o_d;
  assign drive_q_d = drive_en;

  always_ff @(posedge fifo_clk_i or posedge reset_i) begin
    if (reset_i) begin
      O_q     <= '0;
      drive_q <= 1'b0;
    end else begin
      O_q     <= o_q_d;
      drive_q <= drive_q_d;
    end
  end

endmodule

// File: tb/tb_trellis_bidir_io_bank.sv
// ---------------------------------------------------------------------------
// tb_trellis_bidir_io_bank
//
// Bench for trellis_bidir_io_bank with three instances, one per mode (BIDIR,
// INPUT, OUTPUT). The instances share the clock, the reset, T and I. Each
// instance has its own pad net and its own external driver.
// ---------------------------------------------------------------------------
module tb_trellis_bidir_io_bank;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         fifo_clk_i;
  logic         reset_i;
  logic         T;
  logic [W-1:0] I;

  initial fifo_clk_i = 1'b0;
  always #5 fifo_clk_i = ~fifo_clk_i;

  // BIDIR instance
  wire  [W-1:0] B_bi;
  logic         ext_bi_en;
  logic [W-1:0] ext_bi_val;
  logic [W-1:0] O_bi, O_q_bi;
  logic         drive_q_bi;
  assign B_bi = ext_bi_en ? ext_bi_val : {W{1'bz}};

  // INPUT instance
  wire  [W-1:0] B_in;
  logic         ext_in_en;
  logic [W-1:0] ext_in_val;
  logic [W-1:0] O_in, O_q_in;
  logic         drive_q_in;
  assign B_in = ext_in_en ? ext_in_val : {W{1'bz}};

  // OUTPUT instance (nothing external drives its pads)
  wire  [W-1:0] B_out;
  logic [W-1:0] O_out, O_q_out;
  logic         drive_q_out;

  trellis_bidir_io_bank #(.WIDTH(W), .DIR("BIDIR")) u_bi (
    .fifo_clk_i(fifo_clk_i), .reset_i(reset_i), .B(B_bi), .T(T), .I(I),
    .O(O_bi), .O_q(O_q_bi), .drive_q(drive_q_bi)
  );

  trellis_bidir_io_bank #(.WIDTH(W), .DIR("INPUT")) u_in (
    .fifo_clk_i(fifo_clk_i), .reset_i(reset_i), .B(B_in), .T(T), .I(I),
    .O(O_in), .O_q(O_q_in), .drive_q(drive_q_in)
  );

  trellis_bidir_io_bank #(.WIDTH(W), .DIR("OUTPUT")) u_out (
    .fifo_clk_i(fifo_clk_i), .reset_i(reset_i), .B(B_out), .T(T), .I(I),
    .O(O_out), .O_q(O_q_out), .drive_q(drive_q_out)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Move 1 time unit past the next rising edge so outputs are sampled away
  // from the edge.
  task automatic step();
    @(posedge fifo_clk_i);
    #1;
  endtask

  // Pop the oldest expected value and compare it with O_q of the BIDIR bank.
  task automatic check_bi_oq(input string name);
    logic [W-1:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, O_q=%h", name, O_q_bi);
    end else begin
      exp = exp_q.pop_front();
      if (O_q_bi !== exp) begin
        bad++;
        $display("FAIL %s: O_q=%h expected %h", name, O_q_bi, exp);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_i = 1'b0; T = 1'b0; I = 8'hA5;
    ext_bi_en = 1'b0; ext_in_en = 1'b0;
    exp_q.push_back(8'hA5);
    step();
    check_bi_oq("reset_preload");
    // Assert reset mid-cycle. The flops must clear before the next edge.
    #2 reset_i = 1'b1;
    #1;
    total++;
    if (O_q_bi !== 8'h00) begin
      bad++; $display("FAIL reset_async_oq: O_q=%h expected 00", O_q_bi);
    end
    total++;
    if (drive_q_bi !== 1'b0) begin
      bad++; $display("FAIL reset_async_drive: drive_q=%b expected 0", drive_q_bi);
    end
    // While reset is high the pads are still driven.
    total++;
    if (B_bi !== 8'hA5) begin
      bad++; $display("FAIL reset_pad_active: B=%h expected a5", B_bi);
    end
    step();
    total++;
    if (O_q_bi !== 8'h00 || O_q_out !== 8'h00 || drive_q_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_held: O_q=%h O_q_out=%h drive_q_out=%b expected 00/00/0",
               O_q_bi, O_q_out, drive_q_out);
    end
    #2 reset_i = 1'b0;
    I = 8'h69;
    exp_q.push_back(8'h69);
    step();
    check_bi_oq("reset_release_follow");
  endtask

  task automatic test_bidir_drive();
    T = 1'b0; I = 8'h3C; ext_bi_en = 1'b0;
    #1;
    total++;
    if (B_bi !== 8'h3C || O_bi !== 8'h3C) begin
      bad++; $display("FAIL bidir_drive_comb: B=%h O=%h expected 3c/3c", B_bi, O_bi);
    end
    exp_q.push_back(8'h3C);
    step();
    check_bi_oq("bidir_drive_oq");
    total++;
    if (drive_q_bi !== 1'b1) begin
      bad++; $display("FAIL bidir_drive_flag: drive_q=%b expected 1", drive_q_bi);
    end
  endtask

  task automatic test_bidir_receive();
    T = 1'b1; I = 8'hFF;
    ext_bi_val = 8'h5A; ext_bi_en = 1'b1;
    #1;
    total++;
    if (B_bi !== 8'h5A || O_bi !== 8'h5A) begin
      bad++; $display("FAIL bidir_receive_comb: B=%h O=%h expected 5a/5a", B_bi, O_bi);
    end
    exp_q.push_back(8'h5A);
    step();
    check_bi_oq("bidir_receive_oq");
    total++;
    if (drive_q_bi !== 1'b0) begin
      bad++; $display("FAIL bidir_receive_flag: drive_q=%b expected 0", drive_q_bi);
    end
    ext_bi_en = 1'b0;
  endtask

  task automatic test_turnaround();
    T = 1'b0; I = 8'h11; ext_bi_en = 1'b0;
    exp_q.push_back(8'h11);
    step();
    check_bi_oq("turn_drive_oq");
    // Release the bus. Nobody drives it for this cycle.
    T = 1'b1;
    #1;
    total++;
    if (B_bi === 8'h11) begin
      bad++; $display("FAIL turn_release: B=%h expected not driven with 11", B_bi);
    end
    step();
    total++;
    if (drive_q_bi !== 1'b0 || O_q_bi === 8'h11) begin
      bad++; $display("FAIL turn_gap: drive_q=%b O_q=%h expected 0 and not 11",
                      drive_q_bi, O_q_bi);
    end
    ext_bi_val = 8'hC3; ext_bi_en = 1'b1;
    exp_q.push_back(8'hC3);
    step();
    check_bi_oq("turn_external_oq");
    ext_bi_en = 1'b0;
  endtask

  task automatic test_input_mode();
    T = 1'b0; I = 8'h81; ext_in_en = 1'b0;
    #1;
    total++;
    if (B_in === 8'h81) begin
      bad++; $display("FAIL input_no_drive: B=%h expected high-Z", B_in);
    end
    // An external driver must win cleanly because the bank never drives.
    ext_in_val = 8'h42; ext_in_en = 1'b1;
    #1;
    total++;
    if (B_in !== 8'h42 || O_in !== 8'h42) begin
      bad++; $display("FAIL input_receive: B=%h O=%h expected 42/42", B_in, O_in);
    end
    step();
    total++;
    if (drive_q_in !== 1'b0 || O_q_in !== 8'h42) begin
      bad++; $display("FAIL input_registered: drive_q=%b O_q=%h expected 0/42",
                      drive_q_in, O_q_in);
    end
    ext_in_en = 1'b0;
  endtask

  task automatic test_output_mode();
    T = 1'b1; I = 8'h81;
    #1;
    total++;
    if (B_out !== 8'h81 || O_out !== 8'h81) begin
      bad++; $display("FAIL output_comb: B=%h O=%h expected 81/81", B_out, O_out);
    end
    step();
    total++;
    if (drive_q_out !== 1'b1 || O_q_out !== 8'h81) begin
      bad++; $display("FAIL output_registered: drive_q=%b O_q=%h expected 1/81",
                      drive_q_out, O_q_out);
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] v;
    T = 1'b0; ext_bi_en = 1'b0;
    for (int k = 0; k < 256; k++) begin
      v = W'(k);
      I = v;
      exp_q.push_back(v);
      step();
      check_bi_oq("stream");
    end
    // A random burst where adjacent bits toggle independently.
    for (int k = 0; k < 32; k++) begin
      v = W'($urandom_range(0, 255));
      I = v;
      exp_q.push_back(v);
      step();
      check_bi_oq("stream_random");
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL stream_leftover: %0d entries expected 0", exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_i = 1'b1; T = 1'b1; I = '0;
    ext_bi_en = 1'b0; ext_bi_val = '0;
    ext_in_en = 1'b0; ext_in_val = '0;
    #12;
    test_reset();
    test_bidir_drive();
    test_bidir_receive();
    test_turnaround();
    test_input_mode();
    test_output_mode();
    test_streaming();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trellis_bidir_io_bank.md
Name: trellis_bidir_io_bank

Overview:
- Bank of WIDTH bidirectional pad buffers modelled on the ECP5 TRELLIS_IO primitive.
- Used as the 8-bit FT2232H FIFO data bus buffer: one shared tristate control, a per-bit drive value, and a per-bit received value.
- Adds a registered pad sample and a registered drive-status flag, both clocked by fifo_clk_i, for timing-closed consumers.

Parameters:
- WIDTH, 8, number of pad bits in the bank.
- DIR, "BIDIR", buffer mode: "BIDIR", "INPUT" or "OUTPUT"; any other value is an elaboration-time error.

Ports:
- fifo_clk_i  input  1  sampling clock for registered outputs
- reset_i  input  1  asynchronous, active-high reset
- B  inout  WIDTH  pad bus
- T  input  1  tristate control: 1 = pad high-Z (receive), 0 = drive I onto pad; shared by all bits
- I  input  WIDTH  value driven onto the pad when driving
- O  output  WIDTH  combinational received value
- O_q  output  WIDTH  O registered on the rising edge of fifo_clk_i
- drive_q  output  1  registered "bank is driving" flag

Behaviour:
- Combinational pad path, identical for every bit k:
  - DIR="BIDIR": B[k] = I[k] when T=0, else high-Z. O[k] = B[k] (resolved pad value) in both directions. When driving, O therefore returns I.
  - DIR="INPUT": B is never driven (always high-Z); T and I are ignored. O[k] = B[k].
  - DIR="OUTPUT": B[k] = I[k] at all times; T is ignored. O[k] = I[k].
- Zero latency from I/T to B and from B to O; no clock involvement.
- drive_en = (DIR=="OUTPUT") or (DIR=="BIDIR" and T==0).
- Registered path (posedge fifo_clk_i, asynchronous reset):
  - Reset values: O_q = 0, drive_q = 0. Reset takes effect immediately on reset_i rising, independent of the clock.
  - While reset_i is high, the combinational path stays active. The pads are driven per T/DIR regardless of reset.
  - After reset, each rising clock edge: O_q <= O and drive_q <= drive_en.
  - O_q lags O by exactly one clock.
- Direction turnaround:
  - No internal guard cycle. A T change takes effect at the pad immediately.
  - Avoiding bus contention (one clock of high-Z between directions) is the instantiating controller's responsibility.
- Floating pad (receive mode, nothing driving) propagates to O, and to O_q on the next edge, as is. No pull-up or keeper.
- X on T in BIDIR mode: B = X.
- Per-bit independence: the bits share only T. Data on one bit never affects another.
- No state machine. The registered flops are the only state.

Test Plan:
- Reset: assert reset_i mid-cycle with O_q=8'hA5 -> O_q=8'h00 and drive_q=0 immediately, without waiting for a clock edge; after release, O_q follows O on the next edge.
- BIDIR drive: T=0, I=8'h3C -> B=8'h3C and O=8'h3C in the same delta; after one edge, O_q=8'h3C and drive_q=1.
- BIDIR receive: T=1, I=8'hFF, external driver puts 8'h5A on B -> bank does not drive (B resolves to 8'h5A, no X); O=8'h5A; after one edge, O_q=8'h5A and drive_q=0.
- Turnaround: T toggles 0->1 with external driver enabled one clock later -> B is high-Z for that cycle, then carries the external value; O_q sequence is I value, 8'hzz, external value over three edges.
- DIR="INPUT" with T=0 and I=8'h81 -> B stays high-Z and drive_q=0. DIR="OUTPUT" with T=1 and I=8'h81 -> B=8'h81 and drive_q=1.
- Streaming: change I every clock through 8'h00..8'hFF with T=0 -> O_q equals the previous cycle's I on every edge, with no dropped or duplicated values.
